// File: rtl/uart_tx_fifo.sv
// Show-ahead TX FIFO between the user write port and the UART transmitter.
// Define UART_TX_FIFO_CNT_EN to expose the registered occupancy on o_fifo_cnt.
module uart_tx_fifo #(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_FIFO_DEPTH      = 16
) (
  input  logic                                 i_u_clk,
  input  logic                                 i_u_rst,
  input  logic [P_UART_DATA_WIDTH-1:0]         i_user_tx_data,
  input  logic                                 i_user_tx_valid,
  output logic                                 o_user_tx_ready,
  output logic [P_UART_DATA_WIDTH-1:0]         o_uart_tx_data,
  output logic                                 o_uart_tx_valid,
  input  logic                                 i_uart_tx_ready,
  output logic                                 o_fifo_full,
  output logic                                 o_fifo_empty
`ifdef UART_TX_FIFO_CNT_EN
  ,
  output logic [$clog2(P_FIFO_DEPTH):0]        o_fifo_cnt
`endif
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [P_UART_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          full_q, empty_q;
  logic          push, pop;

  // Handshakes use only registered flags, so a push into a full FIFO is
  // refused even when a pop happens in the same cycle.
  assign push = i_user_tx_valid & ~full_q;
  assign pop  = i_uart_tx_ready & ~empty_q;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge i_u_clk) begin
    if (i_u_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt     <= cnt_nxt;
      full_q  <= (cnt_nxt == CW'(P_FIFO_DEPTH));
      empty_q <= (cnt_nxt == '0);
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge i_u_clk) begin
    if (!i_u_rst && push) mem[wr_ptr] <= i_user_tx_data;
  end

  assign o_user_tx_ready = ~full_q;
  assign o_uart_tx_valid = ~empty_q;
  assign o_uart_tx_data  = mem[rd_ptr];
  assign o_fifo_full     = full_q;
  assign o_fifo_empty    = empty_q;
`ifdef UART_TX_FIFO_CNT_EN
  assign o_fifo_cnt      = cnt;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, show-ahead latency, full/refusal,
// reset flush, steady push+pop and a randomized stream with ordering checks.
module tb_uart_tx_fifo;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         full, empty;
`ifdef UART_TX_FIFO_CNT_EN
  logic [CW-1:0] cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.P_UART_DATA_WIDTH(W), .P_FIFO_DEPTH(D)) dut (
    .i_u_clk         (clk),
    .i_u_rst         (rst),
    .i_user_tx_data  (in_data),
    .i_user_tx_valid (in_valid),
    .o_user_tx_ready (in_ready),
    .o_uart_tx_data  (out_data),
    .o_uart_tx_valid (out_valid),
    .i_uart_tx_ready (out_ready),
    .o_fifo_full     (full),
    .o_fifo_empty    (empty)
`ifdef UART_TX_FIFO_CNT_EN
    ,
    .o_fifo_cnt      (cnt)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (empty !== 1'b1)     begin n_errors++; $display("FAIL rst_empty got %b want 1", empty); end
    n_checks++; if (full !== 1'b0)      begin n_errors++; $display("FAIL rst_full got %b want 0", full); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
`ifdef UART_TX_FIFO_CNT_EN
    n_checks++; if (cnt !== '0)         begin n_errors++; $display("FAIL rst_cnt got %0d want 0", cnt); end
`endif
  endtask

  task automatic test_single();
    do_reset();
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid cyc %0d got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== 8'hA5) begin n_errors++; $display("FAIL single_data cyc %0d got %h want a5", i, out_data); end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL single_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < D; i++) begin
      n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL fill_early_full at %0d got %b want 0", i, full); end
      in_valid = 1'b1; in_data = W'(i);
      step();
    end
    n_checks++; if (full !== 1'b1)     begin n_errors++; $display("FAIL full_flag got %b want 1", full); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    in_data = 8'hFF;
    step();
    in_valid = 1'b0;
    n_checks++; if (full !== 1'b1)     begin n_errors++; $display("FAIL refused_full got %b want 1", full); end
    n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL refused_head got %h want 00", out_data); end
  endtask

  task automatic test_push_pop_full();
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL ppf_popped got %h want 00", out_data); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (full !== 1'b0)      begin n_errors++; $display("FAIL ppf_full got %b want 0", full); end
    n_checks++; if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL ppf_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_data !== 8'h01) begin n_errors++; $display("FAIL ppf_head got %h want 01", out_data); end
`ifdef UART_TX_FIFO_CNT_EN
    n_checks++; if (cnt !== CW'(15))    begin n_errors++; $display("FAIL ppf_cnt got %0d want 15", cnt); end
`endif
    out_ready = 1'b1;
    for (int i = 1; i < D; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        n_errors++; $display("FAIL ppf_drain %0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, W'(i));
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL ppf_final_empty got e=%b v=%b want e=1 v=0", empty, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h50 + W'(i);
      step();
    end
    // Push and pop requested during the reset cycle must be ignored.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1)     begin n_errors++; $display("FAIL rmid_empty got %b want 1", empty); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
`ifdef UART_TX_FIFO_CNT_EN
    n_checks++; if (cnt !== '0)         begin n_errors++; $display("FAIL rmid_cnt got %0d want 0", cnt); end
`endif
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_data !== 8'h3C) begin n_errors++; $display("FAIL rmid_head got %h want 3c", out_data); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'h10 + W'(i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'h20 + W'(i);
      exp = (i < 8) ? 8'h10 + W'(i) : 8'h20 + W'(i - 8);
      n_checks++; if (out_data !== exp) begin n_errors++; $display("FAIL b2b_data %0d got %h want %h", i, out_data, exp); end
      n_checks++; if (empty !== 1'b0 || full !== 1'b0) begin
        n_errors++; $display("FAIL b2b_flags %0d got e=%b f=%b want e=0 f=0", i, empty, full);
      end
`ifdef UART_TX_FIFO_CNT_EN
      n_checks++; if (cnt !== CW'(8)) begin n_errors++; $display("FAIL b2b_cnt %0d got %0d want 8", i, cnt); end
`endif
      step();
    end
    in_valid = 1'b0;
    for (int i = 12; i < 20; i++) begin
      n_checks++; if (out_data !== 8'h20 + W'(i)) begin
        n_errors++; $display("FAIL b2b_drain %0d got %h want %h", i, out_data, 8'h20 + W'(i));
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL b2b_final_empty got %b want 1", empty); end
  endtask

  task automatic test_stream();
    logic [W-1:0] bytes [40];
    logic [W-1:0] q [$];
    int sent = 0;
    int got  = 0;
    do_reset();
    for (int i = 0; i < 40; i++) bytes[i] = W'($urandom_range(0, 255));
    for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
      in_valid  = (sent < 40) && ($urandom_range(0, 3) != 0);
      in_data   = (sent < 40) ? bytes[sent] : 8'h00;
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++; $display("FAIL stream_spurious got %h want none", out_data);
        end else begin
          if (out_data !== q[0]) begin n_errors++; $display("FAIL stream_word %0d got %h want %h", got, out_data, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(bytes[sent]);
        sent++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (got != 40 || sent != 40) begin
      n_errors++; $display("FAIL stream_count got rx=%0d tx=%0d want 40/40", got, sent);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_push_pop_full();
    test_reset_mid();
    test_back_to_back();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
